trace_checker: RTL and testbench

Consumer end of the core's trace debug interface (debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata).

- Buffers a golden reference trace pushed in by the testbench or a trace-ROM reader.
- Compares every committed register write from the write-back stage against the head of that buffer.
- Latches the first divergence with full diagnostic context.
- Sits beside mycpu_top in the SoC simulation/FPGA wrapper; replaces software trace comparison so failures are flagged in-system at the cycle they occur.

---
 rtl/trace_checker.sv | 160 ++++++++++++++++
 tb/tb_trace_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker: consumer end of the core's trace debug interface.
// Buffers a golden reference trace in a circular FIFO and compares every
// committed register write (non-zero byte enable, non-r0 destination) against
// the FIFO head. The first divergence, either a mismatch or a commit arriving
// with no golden entry queued, is latched with full diagnostic context.
// Reaching END_PC without a failure flags pass.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   golden_valid/ready       golden entry handshake (pc, wnum, wdata)
//   debug_wb_*               write-back commit trace from the core
//   pass, fail               sticky verdicts
//   err_underrun             failure was a commit with an empty FIFO
//   err_got_*/err_exp_*      observed/expected values at the first failure
//   commit_cnt               number of matched commits (wraps)
//   fifo_level               golden entries currently queued
module trace_checker #(
  parameter int unsigned DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'h1c000100
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       golden_valid,
  output logic                       golden_ready,
  input  logic [31:0]                golden_pc,
  input  logic [4:0]                 golden_wnum,
  input  logic [31:0]                golden_wdata,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_we,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  output logic                       pass,
  output logic                       fail,
  output logic                       err_underrun,
  output logic [31:0]                err_got_pc,
  output logic [31:0]                err_exp_pc,
  output logic [4:0]                 err_got_wnum,
  output logic [4:0]                 err_exp_wnum,
  output logic [31:0]                err_got_wdata,
  output logic [31:0]                err_exp_wdata,
  output logic [31:0]                commit_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_RUN, S_FAIL, S_PASS} state_e;

  state_e      state_q;
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic [AW:0] level_q, level_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pass_q, fail_q, underrun_q;
  logic [31:0] got_pc_q, exp_pc_q, got_wdata_q, exp_wdata_q;
  logic [4:0]  got_wnum_q, exp_wnum_q;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];

  logic        run, commit, empty, full, push, pop, mismatch, bad, to_pass;
  logic [31:0] mask, h_pc, h_wdata;
  logic [4:0]  h_wnum;

  assign h_pc    = mem_pc[rd_q[AW-1:0]];
  assign h_wnum  = mem_wnum[rd_q[AW-1:0]];
  assign h_wdata = mem_wdata[rd_q[AW-1:0]];

  assign run   = (state_q == S_RUN);
  assign empty = (wr_q == rd_q);
  // Pointers carry one wrap bit: full when indices match but wrap bits differ.
  assign full  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});

  // Held low throughout reset even though the state already reads RUN.
  assign golden_ready = resetn && run && !full;

  always_comb begin
    commit   = (debug_wb_rf_we != 4'b0000) && (debug_wb_rf_wnum != 5'd0);
    mask     = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
    mismatch = (debug_wb_pc != h_pc) || (debug_wb_rf_wnum != h_wnum) ||
               (((debug_wb_rf_wdata ^ h_wdata) & mask) != 32'd0);
    push     = golden_valid && golden_ready;
    pop      = run && commit && !empty;
    bad      = run && commit && (empty || mismatch);
    to_pass  = run && !bad && (debug_wb_pc == END_PC);
    wr_d     = push ? wr_q + ONE : wr_q;
    rd_d     = pop  ? rd_q + ONE : rd_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + ONE;
    else if (pop && !push) level_d = level_q - ONE;
    cnt_d    = (pop && !mismatch) ? cnt_q + 32'd1 : cnt_q;
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_q[AW-1:0]]    <= golden_pc;
      mem_wnum[wr_q[AW-1:0]]  <= golden_wnum;
      mem_wdata[wr_q[AW-1:0]] <= golden_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RUN;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      underrun_q  <= 1'b0;
      got_pc_q    <= '0;
      exp_pc_q    <= '0;
      got_wnum_q  <= '0;
      exp_wnum_q  <= '0;
      got_wdata_q <= '0;
      exp_wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      case (state_q)
        S_RUN: begin
          if (bad) begin
            state_q     <= S_FAIL;
            fail_q      <= 1'b1;
            underrun_q  <= empty;
            got_pc_q    <= debug_wb_pc;
            got_wnum_q  <= debug_wb_rf_wnum;
            got_wdata_q <= debug_wb_rf_wdata;
            exp_pc_q    <= empty ? '0 : h_pc;
            exp_wnum_q  <= empty ? '0 : h_wnum;
            exp_wdata_q <= empty ? '0 : h_wdata;
          end else if (to_pass) begin
            state_q <= S_PASS;
            pass_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass          = pass_q;
  assign fail          = fail_q;
  assign err_underrun  = underrun_q;
  assign err_got_pc    = got_pc_q;
  assign err_exp_pc    = exp_pc_q;
  assign err_got_wnum  = got_wnum_q;
  assign err_exp_wnum  = exp_wnum_q;
  assign err_got_wdata = got_wdata_q;
  assign err_exp_wdata = exp_wdata_q;
  assign commit_cnt    = cnt_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_trace_checker.sv
module tb_trace_checker;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] END_PC = 32'h1c000100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        golden_valid = 1'b0;
  logic        golden_ready;
  logic [31:0] golden_pc = '0;
  logic [4:0]  golden_wnum = '0;
  logic [31:0] golden_wdata = '0;
  logic [31:0] debug_wb_pc = '0;
  logic [3:0]  debug_wb_rf_we = '0;
  logic [4:0]  debug_wb_rf_wnum = '0;
  logic [31:0] debug_wb_rf_wdata = '0;
  logic        pass, fail, err_underrun;
  logic [31:0] err_got_pc, err_exp_pc, err_got_wdata, err_exp_wdata, commit_cnt;
  logic [4:0]  err_got_wnum, err_exp_wnum;
  logic [4:0]  fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk), .resetn(resetn),
    .golden_valid(golden_valid), .golden_ready(golden_ready),
    .golden_pc(golden_pc), .golden_wnum(golden_wnum), .golden_wdata(golden_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .pass(pass), .fail(fail), .err_underrun(err_underrun),
    .err_got_pc(err_got_pc), .err_exp_pc(err_exp_pc),
    .err_got_wnum(err_got_wnum), .err_exp_wnum(err_exp_wnum),
    .err_got_wdata(err_got_wdata), .err_exp_wdata(err_exp_wdata),
    .commit_cnt(commit_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: inputs change on the falling edge, outputs are read
  // on the following falling edge (after one rising edge).
  task automatic set_golden(input logic v, input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    golden_valid = v; golden_pc = pc; golden_wnum = wn; golden_wdata = wd;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
  endtask

  task automatic idle;
    set_golden(1'b0, '0, '0, '0);
    set_commit('0, '0, '0, '0);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    set_golden(1'b1, pc, wn, wd);
    @(negedge clk);
    set_golden(1'b0, '0, '0, '0);
  endtask

  task automatic commit1(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] wd);
    set_commit(pc, we, wn, wd);
    @(negedge clk);
    set_commit('0, '0, '0, '0);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] ent_pc(input int k);
    return 32'h1c001000 + 32'(k) * 32'd4;
  endfunction
  function automatic logic [4:0] ent_wn(input int k);
    return 5'((k % 31) + 1);
  endfunction
  function automatic logic [31:0] ent_wd(input int k);
    return 32'hA5000000 + 32'(k);
  endfunction

  task automatic test_reset;
    #12;
    n_cmp++; if (golden_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", golden_ready); end
    n_cmp++; if ({pass, fail, err_underrun} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b exp 000", {pass, fail, err_underrun}); end
    n_cmp++; if (commit_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %h exp 0", commit_cnt); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    n_cmp++; if ({err_got_pc, err_exp_pc, err_got_wdata, err_exp_wdata, err_got_wnum, err_exp_wnum} !== '0) begin
      n_bad++; $display("FAIL rst_err got nonzero exp 0"); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++; if (golden_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got %b exp 1", golden_ready); end
  endtask

  task automatic test_match_run;
    apply_reset();
    push1(32'h1c000000, 5'd1, 32'h00000001);
    push1(32'h1c000004, 5'd2, 32'h00000002);
    push1(32'h1c000008, 5'd3, 32'h00000003);
    n_cmp++; if (fifo_level !== 5'd3) begin n_bad++; $display("FAIL match_lvl3 got %0d exp 3", fifo_level); end
    set_commit(32'h1c000000, 4'hF, 5'd1, 32'h00000001); @(negedge clk);
    set_commit(32'h1c000004, 4'hF, 5'd2, 32'h00000002); @(negedge clk);
    set_commit(32'h1c000008, 4'hF, 5'd3, 32'h00000003); @(negedge clk);
    idle();
    n_cmp++; if (commit_cnt !== 32'd3) begin n_bad++; $display("FAIL match_cnt got %0d exp 3", commit_cnt); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL match_lvl got %0d exp 0", fifo_level); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL match_fail got %b exp 0", fail); end
  endtask

  task automatic test_data_mismatch;
    apply_reset();
    push1(32'h1c000010, 5'd4, 32'h12345678);
    commit1(32'h1c000010, 4'hF, 5'd4, 32'h12345679);
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL dm_fail got %b exp 1", fail); end
    n_cmp++; if (err_exp_wdata !== 32'h12345678) begin n_bad++; $display("FAIL dm_exp_wdata got %h exp 12345678", err_exp_wdata); end
    n_cmp++; if (err_got_wdata !== 32'h12345679) begin n_bad++; $display("FAIL dm_got_wdata got %h exp 12345679", err_got_wdata); end
    n_cmp++; if (err_exp_pc !== 32'h1c000010) begin n_bad++; $display("FAIL dm_exp_pc got %h exp 1c000010", err_exp_pc); end
    n_cmp++; if (err_got_wnum !== 5'd4) begin n_bad++; $display("FAIL dm_got_wnum got %0d exp 4", err_got_wnum); end
    n_cmp++; if (err_underrun !== 1'b0) begin n_bad++; $display("FAIL dm_underrun got %b exp 0", err_underrun); end
    n_cmp++; if (commit_cnt !== 32'd0) begin n_bad++; $display("FAIL dm_cnt got %0d exp 0", commit_cnt); end
    n_cmp++; if (golden_ready !== 1'b0) begin n_bad++; $display("FAIL dm_ready got %b exp 0", golden_ready); end
    commit1(END_PC, 4'h0, 5'd0, 32'h0);
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL dm_pass got %b exp 0", pass); end
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL dm_sticky got %b exp 1", fail); end
  endtask

  task automatic test_byte_mask;
    apply_reset();
    push1(32'h1c000020, 5'd6, 32'hAABBCCDD);
    push1(32'h1c000024, 5'd6, 32'hAABBCCDD);
    commit1(32'h1c000020, 4'b0001, 5'd6, 32'h000000DD);
    n_cmp++; if ({fail, commit_cnt} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL bm_match got fail=%b cnt=%0d exp fail=0 cnt=1", fail, commit_cnt); end
    commit1(32'h1c000024, 4'b0011, 5'd6, 32'h000000DD);
    n_cmp++; if ({fail, commit_cnt} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL bm_mism got fail=%b cnt=%0d exp fail=1 cnt=1", fail, commit_cnt); end
  endtask

  task automatic test_underrun;
    apply_reset();
    commit1(32'h1c000030, 4'hF, 5'd0, 32'h11111111);
    n_cmp++; if ({fail, commit_cnt} !== {1'b0, 32'd0}) begin n_bad++; $display("FAIL ur_r0 got fail=%b cnt=%0d exp fail=0 cnt=0", fail, commit_cnt); end
    commit1(32'h1c000034, 4'hF, 5'd5, 32'h00000055);
    n_cmp++; if ({fail, err_underrun} !== 2'b11) begin n_bad++; $display("FAIL ur_flags got %b exp 11", {fail, err_underrun}); end
    n_cmp++; if ({err_exp_pc, err_exp_wnum, err_exp_wdata} !== '0) begin n_bad++; $display("FAIL ur_exp got %h/%0d/%h exp 0", err_exp_pc, err_exp_wnum, err_exp_wdata); end
    n_cmp++; if ({err_got_pc, err_got_wnum} !== {32'h1c000034, 5'd5}) begin n_bad++; $display("FAIL ur_got got %h/%0d exp 1c000034/5", err_got_pc, err_got_wnum); end
    // No same-cycle bypass: push and commit together into an empty FIFO.
    apply_reset();
    set_golden(1'b1, 32'h1c000040, 5'd8, 32'h88);
    set_commit(32'h1c000040, 4'hF, 5'd8, 32'h88);
    @(negedge clk);
    idle();
    n_cmp++; if ({fail, err_underrun} !== 2'b11) begin n_bad++; $display("FAIL ur_bypass got %b exp 11", {fail, err_underrun}); end
  endtask

  task automatic test_full_wrap;
    int pushed, committed;
    apply_reset();
    for (int k = 0; k < int'(DEPTH); k++) push1(ent_pc(k), ent_wn(k), ent_wd(k));
    n_cmp++; if (golden_ready !== 1'b0) begin n_bad++; $display("FAIL fw_ready got %b exp 0", golden_ready); end
    n_cmp++; if (fifo_level !== 5'(DEPTH)) begin n_bad++; $display("FAIL fw_lvl got %0d exp %0d", fifo_level, DEPTH); end
    // Offer a poisoned entry while full and popping: it must be refused.
    set_golden(1'b1, 32'hDEADBEEF, 5'd31, 32'hDEADBEEF);
    set_commit(ent_pc(0), 4'hF, ent_wn(0), ent_wd(0));
    @(negedge clk);
    idle();
    n_cmp++; if (fifo_level !== 5'(DEPTH - 1)) begin n_bad++; $display("FAIL fw_refuse got %0d exp %0d", fifo_level, DEPTH - 1); end
    pushed = int'(DEPTH);
    committed = 1;
    while (committed < 3 * int'(DEPTH)) begin
      if (pushed < 3 * int'(DEPTH)) begin
        set_golden(1'b1, ent_pc(pushed), ent_wn(pushed), ent_wd(pushed));
        pushed++;
      end else set_golden(1'b0, '0, '0, '0);
      set_commit(ent_pc(committed), 4'hF, ent_wn(committed), ent_wd(committed));
      committed++;
      @(negedge clk);
    end
    idle();
    n_cmp++; if (commit_cnt !== 32'(3 * DEPTH)) begin n_bad++; $display("FAIL fw_cnt got %0d exp %0d", commit_cnt, 3 * DEPTH); end
    n_cmp++; if ({fail, fifo_level} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL fw_end got fail=%b lvl=%0d exp 0/0", fail, fifo_level); end
  endtask

  task automatic test_end_pass;
    apply_reset();
    push1(END_PC, 5'd7, 32'h77);
    commit1(END_PC, 4'hF, 5'd7, 32'h77);
    n_cmp++; if ({pass, fail} !== 2'b10) begin n_bad++; $display("FAIL ep_pass got %b exp 10", {pass, fail}); end
    n_cmp++; if ({commit_cnt, fifo_level} !== {32'd1, 5'd0}) begin n_bad++; $display("FAIL ep_cnt got %0d/%0d exp 1/0", commit_cnt, fifo_level); end
    // A failing commit at END_PC: fail wins over pass.
    apply_reset();
    push1(END_PC, 5'd7, 32'h77);
    commit1(END_PC, 4'hF, 5'd9, 32'h77);
    n_cmp++; if ({pass, fail} !== 2'b01) begin n_bad++; $display("FAIL ep_prio got %b exp 01", {pass, fail}); end
    n_cmp++; if ({err_got_wnum, err_exp_wnum} !== {5'd9, 5'd7}) begin n_bad++; $display("FAIL ep_wnum got %0d/%0d exp 9/7", err_got_wnum, err_exp_wnum); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    for (int k = 0; k < 6; k++) push1(ent_pc(k), ent_wn(k), ent_wd(k));
    commit1(ent_pc(0), 4'hF, ent_wn(0), ent_wd(0));
    n_cmp++; if ({commit_cnt, fifo_level} !== {32'd1, 5'd5}) begin n_bad++; $display("FAIL rm_pre got %0d/%0d exp 1/5", commit_cnt, fifo_level); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({commit_cnt, fifo_level, golden_ready, pass, fail} !== '0) begin
      n_bad++; $display("FAIL rm_async got cnt=%0d lvl=%0d rdy=%b exp all 0", commit_cnt, fifo_level, golden_ready); end
    @(negedge clk);
    resetn = 1'b1;
    push1(32'h1c000050, 5'd10, 32'hCAFE0001);
    commit1(32'h1c000050, 4'hF, 5'd10, 32'hCAFE0001);
    n_cmp++; if ({fail, commit_cnt} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL rm_fresh got fail=%b cnt=%0d exp 0/1", fail, commit_cnt); end
  endtask

  initial begin
    test_reset();
    test_match_run();
    test_data_mismatch();
    test_byte_mask();
    test_underrun();
    test_full_wrap();
    test_end_pass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
